// File: rtl/ysyx_23060187_pkg.sv
// Shared definitions for the ysyx_23060187 core: machine width, the IFU
// state encoding, the fetch-buffer entry layout and the RV32 major opcodes
// the main controller decodes out of inst[6:0].
package ysyx_23060187_pkg;

  localparam int XLEN = 32;

  // PC of the first fetch after reset, used unless the top overrides it.
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

  // Fetch FSM: IDLE may issue, WAIT owns one outstanding request,
  // DROP owns one outstanding request whose response is stale.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } ifu_state_e;

  // One buffered fetch result as handed to the decoder.
  typedef struct packed {
    logic            err;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  // RV32I major opcodes (inst[6:0]).
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Fetch addresses are always word aligned; low two bits are dropped.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ysyx_23060187_ifu_fifo.sv
// Small synchronous FIFO of fetch results. Flush empties it in one cycle and
// overrides any push or pop in the same cycle. The head is presented as zero
// whenever the FIFO is empty so the decoder never sees stale data.
module ysyx_23060187_ifu_fifo
  import ysyx_23060187_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && (count != '0);

  // Entry storage write.
  // NOTE: the data array has no reset; only pointers and count do, and the
  // head is masked while empty, so reset contents can never become visible.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally mod DEPTH.
  // NOTE: all state here uses non-blocking assignment so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/ysyx_23060187_ifu.sv
// Instruction fetch unit. Keeps the fetch PC, issues at most one word request
// at a time to instruction memory, buffers responses in a small FIFO and
// hands {inst, pc, err} to the decoder with valid/ready. A redirect flushes
// the buffer, retargets the PC and marks any in-flight response as stale.
module ysyx_23060187_ifu
  import ysyx_23060187_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int              BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            imem_resp_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_err,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int CW = $clog2(BUF_DEPTH + 1);

  ifu_state_e      state;
  ifu_state_e      state_nxt;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] fetch_pc_nxt;
  logic [CW-1:0]   fifo_count;
  fetch_entry_t    fifo_head;
  fetch_entry_t    push_entry;
  logic            req_fire;
  logic            push;
  logic            pop;

  // A request only leaves IDLE, where nothing is outstanding, so free space
  // in the FIFO is enough to guarantee its response has a slot. The request
  // is held low during reset and withdrawn in any redirect cycle.
  assign imem_req_valid = rst_n && (state == IDLE) &&
                          (fifo_count < CW'(BUF_DEPTH)) && !redirect_valid;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // fetch_pc already advanced at the handshake, so the word in flight
  // belongs to fetch_pc - 4.
  assign push       = (state == WAIT) && imem_resp_valid && !redirect_valid;
  assign push_entry = '{err: imem_resp_err, pc: fetch_pc - XLEN'(4), inst: imem_resp_data};
  assign pop        = inst_valid && inst_ready;

  // Next-state and next-PC selection; redirect outranks everything.
  // NOTE: every output of this block gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    if (redirect_valid) begin
      fetch_pc_nxt = align_word(redirect_pc);
      unique case (state)
        IDLE:       state_nxt = IDLE;
        // A response arriving in the redirect cycle retires the old request;
        // otherwise it is still owed and must be discarded when it lands.
        WAIT, DROP: state_nxt = imem_resp_valid ? IDLE : DROP;
        default:    state_nxt = IDLE;
      endcase
    end else begin
      unique case (state)
        IDLE: begin
          if (req_fire) begin
            state_nxt    = WAIT;
            fetch_pc_nxt = fetch_pc + XLEN'(4);
          end
        end
        WAIT:    if (imem_resp_valid) state_nxt = IDLE;
        DROP:    if (imem_resp_valid) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // FSM state and fetch PC registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
    end
  end

  ysyx_23060187_ifu_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  assign inst_valid = (fifo_count != '0);
  assign inst       = fifo_head.inst;
  assign inst_pc    = fifo_head.pc;
  assign inst_err   = fifo_head.err;

endmodule
